alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one small ALU (add/sub/and/double) between NUM_REQ requesters.
- Each requester has a valid/ready command port. A single response port returns the result tagged with the source index.
- Sits between independent control agents and the shared arithmetic datapath, so no agent needs its own adder.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- WIDTH, 4, operand and result width in bits.
- SRC_W, $clog2(NUM_REQ), width of the source tag.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_op  in  NUM_REQ*2  opcode, slice [i*2 +: 2].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_result  out  WIDTH  ALU result.
- rsp_src  out  SRC_W  index of the requester that produced the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Opcodes:
  - 00 ADD: a+b mod 2^WIDTH.
  - 01 SUB: a-b mod 2^WIDTH.
  - 10 AND: a&b.
  - 11 DBL: a+a mod 2^WIDTH; b is ignored.
  - No carry or borrow is exported.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant g is chosen combinationally from req_valid.
  - req_ready[g]=1 only in IDLE and only when req_valid[g]=1.
  - Handshake (valid&ready) captures a, b, op and g into registers; next state is EXEC.
- EXEC:
  - The ALU computes from the captured operands.
  - The result is registered into rsp_result, and g into rsp_src.
  - Next state is RESP.
- RESP:
  - rsp_valid=1. rsp_result and rsp_src hold stable until rsp_valid&rsp_ready.
  - On that handshake, next state is IDLE.
- Latency and throughput:
  - Accept at edge T; rsp_valid is high from T+2.
  - If rsp_ready=1 at T+2, the next accept is possible at T+3.
  - Peak throughput is one op per 3 cycles.
- Requester protocol: once req_valid is high, it and the payload must stay stable until the handshake. Deasserting before grant is legal; the arbiter simply does not select that requester.
- Arbitration: round-robin pointer ptr.
  - The search starts at ptr and wraps from NUM_REQ-1 to 0.
  - On a grant, ptr becomes g+1 mod NUM_REQ. Without a grant, ptr is unchanged.
- Simultaneous events:
  - All requesters valid: grant goes to the first valid index at or above ptr (wrapping).
  - A new request arriving while busy waits; req_ready stays 0 outside IDLE.
  - A rsp_ready stall holds RESP indefinitely, with no loss or overwrite.
- Reset (asynchronous, any time):
  - State becomes IDLE and ptr becomes 0.
  - rsp_valid=0, rsp_result=0, rsp_src=0, busy=0, req_ready=0.
  - An in-flight transaction is discarded and is not replayed.

Optional Feature:
- Macro: ALU_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority. The lowest valid index always wins, and ptr logic is not built.
- All other timing is identical in both builds.

Decomposition:
- Package alu_arb_pkg holds:
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_DBL.
  - The 2-bit FSM state typedef.
- One sub-module, alu_arb_unit: the combinational WIDTH-bit ALU with inputs a, b, op and output result, instantiated once.
- The arbiter/grant function stays in the top module.

Test Plan:
- WIDTH=4; requester 2 sends a=9, b=8, op=ADD; rsp_ready=1 -> req_ready[2] pulses once; rsp_valid two cycles later with rsp_result=1, rsp_src=2.
- Ops with a=3, b=5: SUB -> 14; AND -> 1; DBL -> 6 (b ignored); ADD with a=15, b=15 -> 14.
- Round-robin build: all 4 requesters valid and held, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_src matches; no requester is starved.
- Fixed-priority build: requesters 0 and 3 valid continuously -> every grant goes to 0; requester 3 is never granted until 0 drops valid.
- rsp_ready=0 for 10 cycles after a result -> rsp_valid, rsp_result and rsp_src stable; all req_ready=0; busy=1. Raising rsp_ready completes the handshake and returns to IDLE next cycle.
- Reset asserted during EXEC -> rsp_valid never rises for that op; state IDLE; after release the grant restarts at index 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode encodings and FSM state type.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_DBL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Command/response bundle between the requesters plus result consumer (master) and the arbiter (slave).
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_result;
    logic [SRC_W-1:0]         rsp_src;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_src, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_src, busy
    );

endinterface

// File: rtl/alu_arb_unit.sv
// Combinational WIDTH-bit ALU shared by all requesters; no carry or borrow leaves this block.
module alu_arb_unit
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_DBL:  result = a + a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters via an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest valid index wins.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SRC_W-1:0]   rsp_src_q, rsp_src_d;
    logic [WIDTH-1:0]   alu_result;
    logic [SRC_W-1:0]   grant;
    logic               grant_found;
    logic               accept;
    logic [NUM_REQ-1:0] ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [SRC_W-1:0] ptr_q, ptr_d;

    // Search starts at ptr and wraps, so the most recent winner drops to lowest priority.
    always_comb begin
        int               idx_int;
        logic [SRC_W-1:0] idx;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_int = int'(ptr_q) + k;
            if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
            idx = SRC_W'(idx_int);
            if (!grant_found && bus.req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant       = SRC_W'(i);
                grant_found = 1'b1;
            end
        end
    end
`endif

    assign accept = (state_q == IDLE) && grant_found && !reset;

    alu_arb_unit #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        src_d     = src_q;
        result_d  = result_q;
        rsp_src_d = rsp_src_q;
        ready     = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ready[grant] = 1'b1;
                    a_d          = bus.req_a[int'(grant)*WIDTH +: WIDTH];
                    b_d          = bus.req_b[int'(grant)*WIDTH +: WIDTH];
                    op_d         = bus.req_op[int'(grant)*2 +: 2];
                    src_d        = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d  = alu_result;
                rsp_src_d = src_q;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            src_q     <= '0;
            result_q  <= '0;
            rsp_src_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            src_q     <= src_d;
            result_q  <= result_d;
            rsp_src_q <= rsp_src_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = result_q;
    assign bus.rsp_src    = rsp_src_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
